cp0_exc_ctrl: RTL
=================

Name: cp0_exc_ctrl

Overview:
- Coprocessor 0 for the P7 pipeline. Sits beside the M stage and is the producer end of the exception-redirect interface that the pipeline registers consume.
- Collects exception codes and hardware interrupts from the M stage and decides whether to take an exception or interrupt.
- Raises the flush/redirect request and holds SR, Cause, EPC and PRId.
- Serves mfc0/mtc0 and supplies EPC for eret.

Parameters:
EBASE, 32'h0000_4180, handler entry address driven on EBase
PRID_VAL, 32'h2022_0701, read-only value of PRId (reg 15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
en  in  1  mtc0 write enable (M stage)
CP0Add  in  5  register select for read/write
CP0In  in  32  mtc0 write data
CP0Out  out  32  mfc0 read data (combinational)
VPC  in  32  PC of the instruction currently in M
BDIn  in  1  M instruction is in a branch delay slot
ExcCodeIn  in  5  M-stage exception code, 0 = none
HWInt  in  6  external interrupt lines [5:0]
EXLClr  in  1  eret in M; clears SR.EXL
Req  out  1  take exception/interrupt this cycle (combinational)
EPCOut  out  32  current EPC register value
EBase  out  32  constant EBASE

Behaviour:
- Storage: SR (IM[15:10], EXL[1], IE[0], all other bits read 0); Cause (BD[31], IP[15:10], ExcCode[6:2], all other bits read 0); EPC[31:0].
- Reset (reset=0, async): SR=0, Cause=0, EPC=0. Outputs during reset: Req=0, CP0Out per CP0Add from the zeroed registers, EPCOut=0.
- IntReq = IE & ~EXL & |(HWInt & IM).
- ExcReq = ~EXL & (ExcCodeIn != 0).
- Req = IntReq | ExcReq. Purely combinational, zero latency, so the pipeline registers flush on the same edge.
- Priority: interrupt over exception. When IntReq=1, recorded ExcCode = 0 even if ExcCodeIn != 0.
- Updates on posedge clk when Req=1:
  - EXL <= 1
  - ExcCode <= (IntReq ? 0 : ExcCodeIn)
  - BD <= BDIn
  - EPC <= BDIn ? VPC-4 : VPC (mod 2^32, no alignment masking)
- Cause.IP <= HWInt on every posedge, regardless of Req or EXL.
- EXLClr=1 and Req=0: EXL <= 0 at the edge. Req=1 overrides EXLClr; EXL stays 1.
- mtc0 (en=1, Req=0), applied at the edge:
  - CP0Add=12: SR <= CP0In masked to IM/EXL/IE.
  - CP0Add=14: EPC <= CP0In.
  - CP0Add=13 and 15: writes ignored (read-only).
  - With Req=1 the write is discarded entirely.
- mtc0 to SR together with EXLClr: mtc0 value applied first, then EXLClr forces EXL=0.
- CP0Out:
  - 12 -> SR
  - 13 -> Cause
  - 14 -> EPC
  - 15 -> PRID_VAL
  - any other address -> 0
  - No write-through bypass: a same-cycle write is visible from the next cycle.
- EPCOut is the register value, not forwarded. The hazard unit stalls eret in D while an mtc0 to reg 14 is in E/M.
- EXL=1 masks both interrupts and exceptions; ExcCodeIn is ignored, no register changes except IP.
- Reset asserted mid-exception: all state cleared immediately; Req drops to 0 asynchronously.

Decomposition:
- Shared package cp0_defs:
  - register indices SR=12, CAUSE=13, EPC=14, PRID=15
  - ExcCode constants Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12
  - bit-field positions IM_HI=15, IM_LO=10, EXL=1, IE=0, BD=31, EXC_HI=6, EXC_LO=2
- Single module, no sub-module. Request logic and register file are too small to split.

Test Plan:
- Reset low then release; read 12/13/14/15 -> 0, 0, 0, 32'h2022_0701; Req=0.
- mtc0 SR=32'h0000_FC01; HWInt=6'b000100, VPC=32'h3010, BDIn=0 -> Req=1 same cycle; next cycle SR=32'h0000_FC03, Cause=32'h0000_1000, EPC=32'h3010.
- SR.EXL=0, ExcCodeIn=10 (RI), VPC=32'h3024, BDIn=1 -> Req=1; then EPC=32'h3020, Cause=32'h8000_0028; a second ExcCodeIn=4 while EXL=1 -> Req=0, Cause unchanged.
- IE=1, IM enables line 0, HWInt[0]=1 and ExcCodeIn=8 in the same cycle -> ExcCode recorded 0, EPC=VPC.
- EXL=1, EXLClr=1 -> EXL=0 next cycle. Then mtc0 EPC=32'h5000 with ExcCodeIn=12 in the same cycle -> EPC=VPC, 32'h5000 discarded.
- reset driven low between clock edges while EXL=1 -> SR/Cause/EPC=0 and Req=0 before the next posedge.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | cp0_defs : shared CP0 register indices, ExcCodes, bit fields |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package cp0_defs;
  localparam logic [4:0] SR    = 5'd12;
  localparam logic [4:0] CAUSE = 5'd13;
  localparam logic [4:0] EPC   = 5'd14;
  localparam logic [4:0] PRID  = 5'd15;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam int IM_HI  = 15;
  localparam int IM_LO  = 10;
  localparam int EXL    = 1;
  localparam int IE     = 0;
  localparam int BD     = 31;
  localparam int EXC_HI = 6;
  localparam int EXC_LO = 2;
endpackage
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------+
// | cp0_exc_ctrl : CP0 for P7 - exception/interrupt request,     |
// | SR/Cause/EPC/PRId storage, mfc0/mtc0 and EPC for eret.       |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module cp0_exc_ctrl
  import cp0_defs::*;
#(
  parameter logic [31:0] EBASE    = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL = 32'h2022_0701
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] EBase
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req = ie & ~exl & (|(HWInt & im));
  assign exc_req = ~exl & (ExcCodeIn != EXC_INT);
  // Gated by reset so a pending ExcCodeIn cannot raise Req while held in reset.
  assign Req     = reset & (int_req | exc_req);

  assign EPCOut = epc;
  assign EBase  = EBASE;

  always_comb begin
    sr_val              = '0;
    sr_val[IM_HI:IM_LO] = im;
    sr_val[EXL]         = exl;
    sr_val[IE]          = ie;
  end

  always_comb begin
    cause_val                = '0;
    cause_val[BD]            = bd;
    cause_val[IM_HI:IM_LO]   = ip;
    cause_val[EXC_HI:EXC_LO] = exc_code;
  end

  always_comb begin
    case (CP0Add)
      SR:      CP0Out = sr_val;
      CAUSE:   CP0Out = cause_val;
      EPC:     CP0Out = epc;
      PRID:    CP0Out = PRID_VAL;
      default: CP0Out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? EXC_INT : ExcCodeIn;
        bd       <= BDIn;
        epc      <= BDIn ? (VPC - 32'd4) : VPC;
      end else begin
        if (en && (CP0Add == SR)) begin
          im  <= CP0In[IM_HI:IM_LO];
          exl <= CP0In[EXL];
          ie  <= CP0In[IE];
        end
        if (en && (CP0Add == EPC)) begin
          epc <= CP0In;
        end
        // eret wins over a same-cycle mtc0 to SR for the EXL bit.
        if (EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
